// File: rtl/pos_pkg.sv
// Shared definitions for the position-loop DAC path: frame geometry, FSM states, code mapping.
// Build option: POS_DAC_OFFSET_BINARY_EN selects an offset-binary DAC instead of two's complement.
package pos_pkg;

  localparam int         DAC_FRAME_BITS  = 24;
  localparam int         DAC_DATA_BITS   = 16;
  localparam logic [7:0] DAC_CMD_DEFAULT = 8'h18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } dac_state_t;

  // Maps the signed loop output onto the code the DAC expects.
  function automatic logic [DAC_DATA_BITS-1:0] dac_code(input logic [DAC_DATA_BITS-1:0] raw);
`ifdef POS_DAC_OFFSET_BINARY_EN
    return {~raw[DAC_DATA_BITS-1], raw[DAC_DATA_BITS-2:0]};
`else
    return raw;
`endif
  endfunction

endpackage

// File: rtl/pos_spi_clk_gen.sv
// SCLK generator: CLK_DIV-cycle half periods while enabled, parked low otherwise.
// rise_en/fall_en flag the clock edge at which dac_sclk is about to toggle.
module pos_spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_pid,
  input  logic sys_rstn,
  input  logic en,
  output logic rise_en,
  output logic fall_en,
  output logic dac_sclk
);

  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick    = en && (cnt == CNT_MAX);
  assign rise_en = tick && !dac_sclk;
  assign fall_en = tick && dac_sclk;

  always_ff @(posedge clk_pid or negedge sys_rstn) begin
    if (!sys_rstn) begin
      cnt      <= '0;
      dac_sclk <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      dac_sclk <= 1'b0;
    end else if (tick) begin
      cnt      <= '0;
      dac_sclk <= ~dac_sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pos_dac_spi.sv
// Serialises pos_pid DAC words into 24-bit SPI (mode 1) frames with latest-wins buffering
// and a boot-time midscale frame. Build option: POS_DAC_OFFSET_BINARY_EN (see pos_pkg).
module pos_dac_spi
  import pos_pkg::*;
#(
  parameter int         CLK_DIV        = 2,
  parameter logic [7:0] DAC_CMD        = DAC_CMD_DEFAULT,
  parameter int         CS_IDLE_CYCLES = 2
) (
  input  logic                     clk_pid,
  input  logic                     sys_rstn,
  input  logic [DAC_DATA_BITS-1:0] pos_dac,
  input  logic                     pos_dac_valid,
  output logic                     dac_sclk,
  output logic                     dac_csn,
  output logic                     dac_mosi,
  output logic                     dac_busy,
  output logic                     dac_frame_done,
  output logic [15:0]              dac_overrun_cnt
);

  localparam int PW = 16;

  dac_state_t                state;
  logic [DAC_DATA_BITS-1:0]  held;
  logic                      pending;
  logic [DAC_FRAME_BITS-1:0] shreg;
  logic [4:0]                bit_cnt;
  logic [PW-1:0]             phase_cnt;
  logic                      rise_en;
  logic                      fall_en;
  logic                      claim;

  // An idle FSM takes the held word, or the incoming one straight through when nothing is held.
  assign claim = (state == ST_IDLE) && (pending || pos_dac_valid);

  pos_spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_pid  (clk_pid),
    .sys_rstn (sys_rstn),
    .en       (state == ST_SHIFT),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .dac_sclk (dac_sclk)
  );

  always_ff @(posedge clk_pid or negedge sys_rstn) begin
    if (!sys_rstn) begin
      // NOTE: the held register is reset, not left undefined: pending+0 is what produces the boot frame.
      held            <= '0;
      pending         <= 1'b1;
      dac_overrun_cnt <= '0;
    end else if (pos_dac_valid) begin
      held    <= pos_dac;
      pending <= !(state == ST_IDLE && !pending);
      if (pending && state != ST_IDLE && dac_overrun_cnt != 16'hFFFF)
        dac_overrun_cnt <= dac_overrun_cnt + 16'd1;
    end else if (claim) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_pid or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state          <= ST_IDLE;
      dac_csn        <= 1'b1;
      dac_mosi       <= 1'b0;
      dac_busy       <= 1'b0;
      dac_frame_done <= 1'b0;
      shreg          <= '0;
      bit_cnt        <= '0;
      phase_cnt      <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge values of all state.
      dac_frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (claim) begin
            dac_csn  <= 1'b0;
            dac_busy <= 1'b1;
            shreg    <= {DAC_CMD, dac_code(pending ? held : pos_dac)};
            bit_cnt  <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise_en) begin
            dac_mosi <= shreg[DAC_FRAME_BITS-1];
            shreg    <= {shreg[DAC_FRAME_BITS-2:0], 1'b0};
          end else if (fall_en) begin
            if (bit_cnt == 5'(DAC_FRAME_BITS - 1)) begin
              phase_cnt <= '0;
              state     <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ST_HOLD: begin
          if (phase_cnt == PW'(CLK_DIV - 1)) begin
            dac_csn        <= 1'b1;
            dac_mosi       <= 1'b0;
            dac_frame_done <= 1'b1;
            phase_cnt      <= '0;
            state          <= ST_GAP;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (phase_cnt == PW'(CS_IDLE_CYCLES - 1)) begin
            dac_busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_dac_spi.sv
// Directed bench for pos_dac_spi: decodes SPI frames on SCLK falling edges and checks
// content, timing, latest-wins buffering, overrun counting and reset behaviour.
module tb_pos_dac_spi;

  localparam int CLK_DIV = 2;
  localparam int CS_IDLE = 2;

`ifdef POS_DAC_OFFSET_BINARY_EN
  localparam logic [23:0] BOOT_FRAME = 24'h188000;
  localparam logic [23:0] T2_FRAME   = 24'h189234;
  localparam logic [15:0] T4_DATA    = 16'h7FFF;
`else
  localparam logic [23:0] BOOT_FRAME = 24'h180000;
  localparam logic [23:0] T2_FRAME   = 24'h181234;
  localparam logic [15:0] T4_DATA    = 16'hFFFF;
`endif

  logic        clk_pid = 1'b0;
  logic        sys_rstn = 1'b0;
  logic [15:0] pos_dac = '0;
  logic        pos_dac_valid = 1'b0;
  logic        dac_sclk, dac_csn, dac_mosi, dac_busy, dac_frame_done;
  logic [15:0] dac_overrun_cnt;

  pos_dac_spi #(
    .CLK_DIV        (CLK_DIV),
    .DAC_CMD        (8'h18),
    .CS_IDLE_CYCLES (CS_IDLE)
  ) dut (
    .clk_pid         (clk_pid),
    .sys_rstn        (sys_rstn),
    .pos_dac         (pos_dac),
    .pos_dac_valid   (pos_dac_valid),
    .dac_sclk        (dac_sclk),
    .dac_csn         (dac_csn),
    .dac_mosi        (dac_mosi),
    .dac_busy        (dac_busy),
    .dac_frame_done  (dac_frame_done),
    .dac_overrun_cnt (dac_overrun_cnt)
  );

  always #5 clk_pid = ~clk_pid;

  int cyc = 0;
  always @(posedge clk_pid) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] data;
    int          nbits;
    int          fall;
    int          rise;
  } frame_t;

  frame_t      frames[$];
  frame_t      m_f;
  int          min_gap = 1000000;
  logic        m_prev_csn, m_prev_sclk, m_in_frame, m_have_rise;
  logic [23:0] m_sh;
  int          m_nb, m_fall, m_last_rise;

  int checks = 0;
  int errors = 0;
  int s, n0, c_r, t0, idx, c, k;
  int          s_cyc[50];
  logic [15:0] s_val[50];

  // Frame decoder: shifts MOSI in on each SCLK falling edge while CSN is low.
  initial begin : monitor
    m_prev_csn = 1'b1; m_prev_sclk = 1'b0; m_in_frame = 1'b0; m_have_rise = 1'b0;
    m_sh = '0; m_nb = 0; m_fall = 0; m_last_rise = 0;
    forever begin
      @(negedge clk_pid);
      if (!sys_rstn) begin
        m_in_frame  = 1'b0;
        m_have_rise = 1'b0;
      end else begin
        if (m_prev_csn && !dac_csn) begin
          m_in_frame = 1'b1; m_sh = '0; m_nb = 0; m_fall = cyc;
          if (m_have_rise && (cyc - m_last_rise) < min_gap) min_gap = cyc - m_last_rise;
        end
        if (m_in_frame && !dac_csn && m_prev_sclk && !dac_sclk) begin
          m_sh = {m_sh[22:0], dac_mosi};
          m_nb++;
        end
        if (m_in_frame && !m_prev_csn && dac_csn) begin
          m_f.data = m_sh; m_f.nbits = m_nb; m_f.fall = m_fall; m_f.rise = cyc;
          frames.push_back(m_f);
          m_last_rise = cyc; m_have_rise = 1'b1; m_in_frame = 1'b0;
        end
      end
      m_prev_csn  = dac_csn;
      m_prev_sclk = dac_sclk;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] exp_frame(input logic [15:0] v);
`ifdef POS_DAC_OFFSET_BINARY_EN
    return {8'h18, ~v[15], v[14:0]};
`else
    return {8'h18, v};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    pos_dac       = v;
    pos_dac_valid = 1'b1;
    @(negedge clk_pid);
    pos_dac_valid = 1'b0;
    pos_dac       = ~v;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_pid);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int w;
    w = 0;
    while (frames.size() < n && w < budget) begin
      @(negedge clk_pid);
      w++;
    end
    check("frame_arrival", frames.size() >= n, 1);
  endtask

  initial begin : stimulus
    // Reset values
    repeat (3) @(negedge clk_pid);
    check("rst_csn", dac_csn, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_mosi", dac_mosi, 0);
    check("rst_busy", dac_busy, 0);
    check("rst_done", dac_frame_done, 0);
    check("rst_ovr", dac_overrun_cnt, 0);

    // 1: boot midscale frame, exactly once
    c_r = cyc;
    sys_rstn = 1'b1;
    wait_frames(1, 300);
    check("boot_data", frames[0].data, BOOT_FRAME);
    check("boot_bits", frames[0].nbits, 24);
    check("boot_fall", frames[0].fall, c_r + 1);
    repeat (200) @(negedge clk_pid);
    check("boot_once", frames.size(), 1);
    check("boot_idle_busy", dac_busy, 0);

    // 2: single strobe, exact timing
    n0 = frames.size();
    s = cyc;
    strobe(16'h1234);
    check("t2_csn_low", dac_csn, 0);
    check("t2_busy_hi", dac_busy, 1);
    wait_cyc(s + 98);
    check("t2_csn_still_low", dac_csn, 0);
    check("t2_done_early", dac_frame_done, 0);
    wait_cyc(s + 99);
    check("t2_csn_high", dac_csn, 1);
    check("t2_done", dac_frame_done, 1);
    check("t2_mosi_idle", dac_mosi, 0);
    wait_cyc(s + 100);
    check("t2_done_pulse", dac_frame_done, 0);
    check("t2_busy_gap", dac_busy, 1);
    wait_cyc(s + 101);
    check("t2_busy_fall", dac_busy, 0);
    wait_frames(n0 + 1, 50);
    check("t2_data", frames[n0].data, T2_FRAME);
    check("t2_fall", frames[n0].fall, s + 1);
    check("t2_rise", frames[n0].rise, s + 99);

    // 3: latest-wins during SHIFT
    repeat (5) @(negedge clk_pid);
    n0 = frames.size();
    s = cyc;
    strobe(16'h0100);
    wait_cyc(s + 20);
    strobe(16'h0200);
    wait_cyc(s + 40);
    strobe(16'h0300);
    wait_frames(n0 + 2, 400);
    repeat (150) @(negedge clk_pid);
    check("t3_count", frames.size(), n0 + 2);
    check("t3_first", frames[n0].data, exp_frame(16'h0100));
    check("t3_second", frames[n0 + 1].data, exp_frame(16'h0300));
    check("t3_second_fall", frames[n0 + 1].fall, s + 102);
    check("t3_ovr", dac_overrun_cnt, 1);

    // 4: all-ones word
    n0 = frames.size();
    strobe(16'hFFFF);
    wait_frames(n0 + 1, 200);
    check("t4_data_bits", frames[n0].data[15:0], T4_DATA);
    check("t4_cmd", frames[n0].data[23:16], 8'h18);

    // Strobes in the IDLE-claim cycle and in the frame_done cycle are not overruns
    repeat (10) @(negedge clk_pid);
    n0 = frames.size();
    s = cyc;
    strobe(16'h1111);
    wait_cyc(s + 50);
    strobe(16'h2222);
    wait_cyc(s + 101);
    strobe(16'h3333);
    wait_cyc(s + 301);
    check("sim_done_cycle", dac_frame_done, 1);
    strobe(16'h4444);
    wait_frames(n0 + 4, 600);
    check("sim_a", frames[n0].data, exp_frame(16'h1111));
    check("sim_b", frames[n0 + 1].data, exp_frame(16'h2222));
    check("sim_c", frames[n0 + 2].data, exp_frame(16'h3333));
    check("sim_d", frames[n0 + 3].data, exp_frame(16'h4444));
    check("sim_b_fall", frames[n0 + 1].fall, s + 102);
    check("sim_c_fall", frames[n0 + 2].fall, s + 203);
    check("sim_d_fall", frames[n0 + 3].fall, s + 304);
    check("sim_ovr", dac_overrun_cnt, 1);

    // 5: reset during bit 10 aborts the frame; boot frame follows
    repeat (10) @(negedge clk_pid);
    n0 = frames.size();
    s = cyc;
    strobe(16'hFFFF);
    wait_cyc(s + 45);
    check("t5_in_frame", dac_csn, 0);
    check("t5_mosi_pre", dac_mosi, 1);
    sys_rstn = 1'b0;
    #1;
    check("t5_csn", dac_csn, 1);
    check("t5_sclk", dac_sclk, 0);
    check("t5_mosi", dac_mosi, 0);
    check("t5_busy", dac_busy, 0);
    repeat (3) @(negedge clk_pid);
    check("t5_ovr_clr", dac_overrun_cnt, 0);
    check("t5_no_partial", frames.size(), n0);
    c_r = cyc;
    sys_rstn = 1'b1;
    wait_frames(n0 + 1, 300);
    check("t5_boot", frames[n0].data, BOOT_FRAME);
    check("t5_boot_fall", frames[n0].fall, c_r + 1);
    repeat (20) @(negedge clk_pid);

    // 6: strobes every 40 cycles for 2000 cycles
    n0 = frames.size();
    t0 = cyc + 2;
    for (int i = 0; i < 50; i++) begin
      wait_cyc(t0 + 40 * i);
      s_cyc[i] = cyc;
      s_val[i] = 16'($urandom);
      strobe(s_val[i]);
    end
    repeat (400) @(negedge clk_pid);
    check("t6_idle", dac_busy, 0);
    idx = 0;
    for (int j = n0; j < frames.size(); j++) begin
      c = frames[j].fall - 1;
      k = -1;
      for (int m = idx; m < 50; m++) if (s_cyc[m] < c) k = m;
      if (k >= 0) begin
        check("t6_data", frames[j].data, exp_frame(s_val[k]));
        idx = k + 1;
      end else if (idx < 50 && s_cyc[idx] == c) begin
        check("t6_data", frames[j].data, exp_frame(s_val[idx]));
        idx++;
      end else begin
        check("t6_source", 0, 1);
      end
    end
    check("t6_all_consumed", idx, 50);
    check("t6_ovr", dac_overrun_cnt, 50 - (frames.size() - n0));
    check("t6_min_gap", min_gap >= CS_IDLE, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
